pov_spi_rx: RTL and testbench

Upstream feeder for the renderer top: receives a full set of view vectors (player position, facing, view plane) over a slave-only SPI link and double-buffers them. Presents them to the wall tracer and overlays so they change only at the visible-frame-end strobe. All six vectors are signed fixed-point, Q12.12 (24 bits).

---
 rtl/pov_spi_rx_pkg.sv | 42 ++++
 rtl/pov_spi_rx_spi_sync_edge.sv | 66 ++++++
 rtl/pov_spi_rx.sv | 198 +++++++++++++++++++
 tb/tb_pov_spi_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pov_spi_rx_pkg.sv
// Shared fixed-point parameters for the view-vector path.
// Provides the Q12.12 format constants, the reset/default view vectors,
// the SPI frame length and the receiver FSM state type.
`ifndef POV_SPI_RX_PKG_SV
`define POV_SPI_RX_PKG_SV

// Bit range of one fixed-point vector, resolved against W in the using scope.
`define F [W-1:0]

package fixed_point_params;

  localparam int QM         = 12;
  localparam int QN         = 12;
  localparam int W          = QM + QN;
  localparam int NVEC       = 6;
  localparam int FRAME_BITS = NVEC * W;

  // Default camera: player at (1.5, 1.5), facing +Y, view plane 0.5 wide.
  localparam logic `F PLAYER_X_DEF = 24'h001800;
  localparam logic `F PLAYER_Y_DEF = 24'h001800;
  localparam logic `F FACING_X_DEF = 24'h000000;
  localparam logic `F FACING_Y_DEF = 24'h001000;
  localparam logic `F VPLANE_X_DEF = 24'h000800;
  localparam logic `F VPLANE_Y_DEF = 24'h000000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RECV    = 3'd1,
    ST_OVERRUN = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_ABORT   = 3'd4
  } rx_state_e;

  // Default vectors packed in frame order (playerX in the top bits).
  function automatic logic [FRAME_BITS-1:0] default_frame();
    return {PLAYER_X_DEF, PLAYER_Y_DEF, FACING_X_DEF,
            FACING_Y_DEF, VPLANE_X_DEF, VPLANE_Y_DEF};
  endfunction

endpackage

`endif

// File: rtl/pov_spi_rx_spi_sync_edge.sv
// spi_sync_edge: brings the three asynchronous SPI pins into the clk domain
// and produces single-cycle edge strobes.
// Ports:
//   clk, reset            system clock, async active-high reset
//   i_sclk/i_mosi/i_ss_n  raw SPI pins
//   sclk_rise             one-clk strobe per synchronised sclk rising edge
//   mosi_s, ss_n_s        synchronised data and select levels
//   ss_fall, ss_rise      one-clk strobes on synchronised select edges
// SYNC_STAGES must be at least 2.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sclk,
  input  logic i_mosi,
  input  logic i_ss_n,
  output logic sclk_rise,
  output logic mosi_s,
  output logic ss_n_s,
  output logic ss_fall,
  output logic ss_rise
);

  localparam int MSB = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q,   ss_prev_d;

  // Next values of the synchroniser chains and the edge-detect history flops.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0],   i_ss_n};
    sclk_prev_d = sclk_sync_q[MSB];
    ss_prev_d   = ss_sync_q[MSB];
  end

  // Synchroniser and history registers; select resets to the idle (high) level
  // so no spurious edge is seen when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
    end
  end

  assign mosi_s    = mosi_sync_q[MSB];
  assign ss_n_s    = ss_sync_q[MSB];
  assign sclk_rise = sclk_sync_q[MSB] & ~sclk_prev_q;
  assign ss_fall   = ss_prev_q & ~ss_sync_q[MSB];
  assign ss_rise   = ~ss_prev_q & ss_sync_q[MSB];

endmodule

// File: rtl/pov_spi_rx.sv
// pov_spi_rx: slave-only SPI receiver for the six view vectors.
// A complete 144-bit frame lands in a shadow buffer; the live outputs are
// updated from the shadow only on load_if_ready, so downstream logic sees
// vectors that are stable for a whole video frame.
// Ports:
//   clk, reset                 pixel clock, async active-high reset
//   i_sclk, i_mosi, i_ss_n     SPI mode 0 slave pins (async to clk)
//   load_if_ready              end-of-visible-frame strobe
//   playerX..vplaneY           live Q12.12 vectors (registered)
//   o_ready                    shadow holds a complete, not yet loaded frame
//   o_loaded                   one-clk pulse when the live vectors change
//   o_frame_err                one-clk pulse when a frame is discarded
module pov_spi_rx
  import fixed_point_params::*;
#(
  parameter int W           = fixed_point_params::W,
  parameter int NVEC        = fixed_point_params::NVEC,
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    i_sclk,
  input  logic    i_mosi,
  input  logic    i_ss_n,
  input  logic    load_if_ready,
  output logic `F playerX,
  output logic `F playerY,
  output logic `F facingX,
  output logic `F facingY,
  output logic `F vplaneX,
  output logic `F vplaneY,
  output logic    o_ready,
  output logic    o_loaded,
  output logic    o_frame_err
);

  localparam int              FBITS    = NVEC * W;
  localparam int              CW       = 8;
  localparam logic [CW-1:0]   FULL_CNT = CW'(FBITS);
  localparam logic [FBITS-1:0] DEF_FRAME = FBITS'(default_frame());

  logic sclk_rise, mosi_s, ss_n_s, ss_fall, ss_rise;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .i_sclk    (i_sclk),
    .i_mosi    (i_mosi),
    .i_ss_n    (i_ss_n),
    .sclk_rise (sclk_rise),
    .mosi_s    (mosi_s),
    .ss_n_s    (ss_n_s),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise)
  );

  rx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FBITS-1:0] shift_q, shift_d;
  logic [FBITS-1:0] shadow_q, shadow_d;
  logic [FBITS-1:0] live_q, live_d;
  logic             ready_q, ready_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic             load_fire;
  logic             bit_edge;

  // A data bit is only taken while the synchronised select is still low.
  assign bit_edge = sclk_rise & ~ss_n_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a select rise takes priority over a coincident bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d = ST_RECV;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (ss_rise) begin
          state_d = (cnt_q == FULL_CNT) ? ST_COMMIT : ST_ABORT;
        end else if (bit_edge && (cnt_q == FULL_CNT)) begin
          state_d = ST_OVERRUN;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_OVERRUN: begin
        if (ss_rise) begin
          state_d = ST_ABORT;
        end else begin
          state_d = ST_OVERRUN;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values: shifting, commit, load and pulses.
  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    load_fire = load_if_ready & ready_q;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          cnt_d   = '0;
          shift_d = '0;
        end else begin
          cnt_d   = cnt_q;
          shift_d = shift_q;
        end
      end
      ST_RECV: begin
        if (!ss_rise && bit_edge && (cnt_q != FULL_CNT)) begin
          shift_d = {shift_q[FBITS-2:0], mosi_s};
          cnt_d   = cnt_q + 8'd1;
        end else begin
          cnt_d   = cnt_q;
          shift_d = shift_q;
        end
      end
      default: begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
      end
    endcase

    // Live takes the shadow as it stood before any same-cycle commit.
    if (load_fire) begin
      live_d = shadow_q;
    end else begin
      live_d = live_q;
    end

    if (state_q == ST_COMMIT) begin
      shadow_d = shift_q;
      ready_d  = 1'b1;
    end else if (load_fire) begin
      shadow_d = shadow_q;
      ready_d  = 1'b0;
    end else begin
      shadow_d = shadow_q;
      ready_d  = ready_q;
    end

    loaded_d = load_fire;
    err_d    = (state_q == ST_ABORT);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      shift_q  <= '0;
      shadow_q <= DEF_FRAME;
      live_q   <= DEF_FRAME;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      live_q   <= live_d;
      ready_q  <= ready_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign playerX     = live_q[FBITS-1       -: W];
  assign playerY     = live_q[FBITS-1 - W   -: W];
  assign facingX     = live_q[FBITS-1 - 2*W -: W];
  assign facingY     = live_q[FBITS-1 - 3*W -: W];
  assign vplaneX     = live_q[FBITS-1 - 4*W -: W];
  assign vplaneY     = live_q[FBITS-1 - 5*W -: W];
  assign o_ready     = ready_q;
  assign o_loaded    = loaded_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_pov_spi_rx.sv
module tb_pov_spi_rx;

  localparam int W = 24;
  typedef logic [143:0] frame_t;

  localparam frame_t DEF = {24'h001800, 24'h001800, 24'h000000,
                            24'h001000, 24'h000800, 24'h000000};
  localparam frame_t F1  = {24'h003400, 24'h002200, 24'hFFF000,
                            24'h000000, 24'h000000, 24'hFFF800};
  localparam frame_t FA  = {24'h00A000, 24'h005800, 24'h000B50,
                            24'hFFF4B0, 24'hFFF8A0, 24'h000760};
  localparam frame_t FB  = {24'h012345, 24'h0ABCDE, 24'hFFF000,
                            24'h000001, 24'h7FFFFF, 24'h800000};
  localparam frame_t FC  = {24'h004000, 24'h003000, 24'h001000,
                            24'h000000, 24'h000000, 24'hFFF6C0};

  logic clk = 1'b0;
  logic reset, i_sclk, i_mosi, i_ss_n, load_if_ready;
  logic [W-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic o_ready, o_loaded, o_frame_err;

  int total = 0;
  int bad   = 0;
  frame_t exp_load_q[$];
  int     err_pending = 0;
  frame_t m_shadow;
  logic   m_ready;

  pov_spi_rx dut (
    .clk           (clk),
    .reset         (reset),
    .i_sclk        (i_sclk),
    .i_mosi        (i_mosi),
    .i_ss_n        (i_ss_n),
    .load_if_ready (load_if_ready),
    .playerX       (playerX),
    .playerY       (playerY),
    .facingX       (facingX),
    .facingY       (facingY),
    .vplaneX       (vplaneX),
    .vplaneY       (vplaneY),
    .o_ready       (o_ready),
    .o_loaded      (o_loaded),
    .o_frame_err   (o_frame_err)
  );

  always #5 clk = ~clk;

  function automatic frame_t outs();
    return {playerX, playerY, facingX, facingY, vplaneX, vplaneY};
  endfunction

  task automatic check(input string name, input frame_t act, input frame_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected loads when o_loaded pulses, tracks error pulses.
  always @(negedge clk) begin
    if (o_loaded === 1'b1) begin
      if (exp_load_q.size() == 0) begin
        check("unexpected_load", frame_t'(o_loaded), frame_t'(0));
      end else begin
        check("load_vectors", outs(), exp_load_q.pop_front());
      end
    end
    if (o_frame_err === 1'b1) begin
      if (err_pending == 0) begin
        check("unexpected_err", frame_t'(o_frame_err), frame_t'(0));
      end else begin
        err_pending--;
      end
    end
  end

  // Clock n bits of f (MSB first) in SPI mode 0 at clk/4; bits past 144 toggle.
  task automatic send_frame(input frame_t f, input int n, input bit raise);
    i_ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      i_mosi = (i < 144) ? f[143-i] : i[0];
      repeat (2) @(negedge clk);
      i_sclk = 1'b1;
      repeat (2) @(negedge clk);
      i_sclk = 1'b0;
    end
    if (raise) begin
      repeat (4) @(negedge clk);
      i_ss_n = 1'b1;
      if (n == 144) begin
        m_shadow = f;
        m_ready  = 1'b1;
      end else begin
        err_pending++;
      end
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic strobe();
    @(negedge clk);
    load_if_ready = 1'b1;
    if (m_ready) begin
      exp_load_q.push_back(m_shadow);
      m_ready = 1'b0;
    end
    @(negedge clk);
    load_if_ready = 1'b0;
  endtask

  task automatic drain_check(input string name);
    repeat (2) @(negedge clk);
    check(name, frame_t'(exp_load_q.size()), frame_t'(0));
  endtask

  initial begin
    reset = 1'b1; i_sclk = 1'b0; i_mosi = 1'b0; i_ss_n = 1'b1; load_if_ready = 1'b0;
    m_shadow = DEF; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vectors", outs(), DEF);
    check("reset_ready", frame_t'(o_ready), frame_t'(0));
    check("reset_loaded", frame_t'(o_loaded), frame_t'(0));
    check("reset_err", frame_t'(o_frame_err), frame_t'(0));
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Short and long frames are discarded.
    send_frame(F1, 143, 1'b1);
    check("short_ready", frame_t'(o_ready), frame_t'(0));
    send_frame(F1, 150, 1'b1);
    check("long_ready", frame_t'(o_ready), frame_t'(0));
    check("err_count", frame_t'(err_pending), frame_t'(0));
    strobe();
    drain_check("no_load_drain");
    check("bad_frames_keep_defaults", outs(), DEF);

    // Valid frame: ready rises, outputs wait for the strobe.
    send_frame(F1, 144, 1'b1);
    check("f1_ready", frame_t'(o_ready), frame_t'(1));
    check("f1_outs_held", outs(), DEF);
    strobe();
    @(negedge clk);
    check("f1_loaded_one_clk", frame_t'(o_loaded), frame_t'(0));
    check("f1_ready_cleared", frame_t'(o_ready), frame_t'(0));
    check("f1_outs_stable", outs(), F1);
    check("f1_drain", frame_t'(exp_load_q.size()), frame_t'(0));

    // Back-to-back frames: newest wins.
    send_frame(FA, 144, 1'b1);
    send_frame(FB, 144, 1'b1);
    check("ab_outs_held", outs(), F1);
    strobe();
    drain_check("ab_drain");

    // Commit coincident with the strobe while A is pending.
    send_frame(FA, 144, 1'b1);
    send_frame(FB, 144, 1'b0);
    repeat (4) @(negedge clk);
    i_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    load_if_ready = 1'b1;
    exp_load_q.push_back(m_shadow);
    m_shadow = FB;
    m_ready  = 1'b1;
    @(negedge clk);
    load_if_ready = 1'b0;
    repeat (6) @(negedge clk);
    check("coincident_ready", frame_t'(o_ready), frame_t'(1));
    check("coincident_drain", frame_t'(exp_load_q.size()), frame_t'(0));
    strobe();
    drain_check("coincident_next_drain");

    // Reset mid-frame, then a clean frame C.
    send_frame(FC, 70, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    i_ss_n = 1'b1;
    i_sclk = 1'b0;
    m_shadow = DEF;
    m_ready  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_outs", outs(), DEF);
    check("midreset_ready", frame_t'(o_ready), frame_t'(0));
    send_frame(FC, 144, 1'b1);
    check("c_ready", frame_t'(o_ready), frame_t'(1));
    strobe();
    drain_check("c_drain");

    repeat (10) @(negedge clk);
    check("final_err_pending", frame_t'(err_pending), frame_t'(0));
    check("final_load_queue", frame_t'(exp_load_q.size()), frame_t'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
